fifo_wptr_full: RTL
===================

FIFO_WPTR_FULL -- requirements
Module: fifo_wptr_full

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning pointer width including the wrap bit; memory depth DEPTH = 2^(ADDR_WIDTH-1).
REQ-002 SHALL have parameter AF_THRESH, default 6, meaning the fill level at or above which walmost_full asserts; legal range 1..DEPTH.
REQ-003 SHALL have port wclk, input, 1 bit: write clock; the only clock.
REQ-004 SHALL have port wrst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of wclk.
REQ-005 SHALL have port winc, input, 1 bit: write request from the producer.
REQ-006 SHALL have port wq2_rptr, input, ADDR_WIDTH bits: Gray read pointer, already two-flop synchronised into wclk.
REQ-007 SHALL have port waddr, output, ADDR_WIDTH-1 bits: memory write address; the low bits of the binary write pointer.
REQ-008 SHALL have port wptr, output, ADDR_WIDTH bits: registered Gray write pointer, exported to the read-domain synchroniser.
REQ-009 SHALL have port wfull, output, 1 bit: registered FIFO-full flag, driven to the memory controller.
REQ-010 SHALL have port wfill, output, ADDR_WIDTH bits: registered fill level, range 0..DEPTH.
REQ-011 SHALL have port wovf, output, 1 bit: sticky overflow flag.
REQ-012 SHALL have port walmost_full, output, 1 bit: almost-full flag; present only under FIFO_ALMOST_FULL_EN.

Function
REQ-013 SHALL accept a write when winc=1 and wfull=0; an accepted write increments the binary pointer wbin by 1, modulo 2^ADDR_WIDTH.
REQ-014 SHALL register the next Gray pointer as wgnext = (wbin_next >> 1) ^ wbin_next, on the same edge as wbin.
REQ-015 SHALL compute wfull from wgnext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]} and register it, so wfull asserts on the same edge as the write that fills the FIFO (zero added latency).
REQ-016 SHALL keep wbin and wptr unchanged when winc=1 and wfull=1, and SHALL set wovf on that edge.
REQ-017 SHALL hold wovf at 1 until reset.
REQ-018 SHALL convert wq2_rptr Gray to binary (rbin), then register wfill = (wbin_next - rbin) mod 2^ADDR_WIDTH.
REQ-019 SHALL wrap wbin from 2^ADDR_WIDTH-1 to 0, toggling the wrap bit; fill arithmetic stays correct across the wrap.
REQ-020 SHALL, when a write and a read-pointer advance occur on the same edge, reflect both in wfill and wfull on that edge.
REQ-021 SHALL deassert wfull only after wq2_rptr advances; this release is pessimistic by the synchroniser latency.

Reset
REQ-022 SHALL, on wrst_n=0 at a wclk edge, set wbin=0, wptr=0, waddr=0, wfull=0, wfill=0, wovf=0, and walmost_full=0.
REQ-023 SHALL make reset asserted mid-stream dominate winc; a write in that cycle is dropped.

Configuration
REQ-024 SHALL, with FIFO_ALMOST_FULL_EN defined, provide walmost_full registered as (wfill_next >= AF_THRESH).
REQ-025 SHALL, without FIFO_ALMOST_FULL_EN, omit the walmost_full port and its logic entirely.

Structure
REQ-026 SHALL place the default ADDR_WIDTH/DATA_WIDTH constants and the DEPTH derivation in shared package fifo_pkg, used by this block and the memory controller.
REQ-027 SHALL instantiate one sub-module, fifo_gray2bin, as a parameterised combinational Gray-to-binary converter, also reused by the read-side pointer block.

Verification
REQ-028 SHALL cover: reset, then 8 writes with wq2_rptr=0 -> waddr steps 0..7, wptr 0,1,3,2,6,7,5,4,C, wfull=1 on the 8th edge, wfill=8.
REQ-029 SHALL cover: full FIFO with winc=1 for 1 cycle -> wptr holds at C, wovf=1 and stays 1.
REQ-030 SHALL cover: full FIFO, wq2_rptr set to 1 -> wfull=0 next edge, wfill=7.
REQ-031 SHALL cover: 20 writes interleaved with read-pointer advances -> wbin wraps 15->0, wfill is never >8 and never negative.
REQ-032 SHALL cover, with FIFO_ALMOST_FULL_EN and AF_THRESH=6: 6 writes -> walmost_full=1 on the 6th edge, 0 after two reads.
REQ-033 SHALL cover: wrst_n=0 with winc=1 and fill=5 -> all outputs 0 the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants used by the write-side pointer block and the memory
// controller. Holds the default pointer and data widths and the depth rule.
package fifo_pkg;

    // Pointer width includes one extra wrap bit above the memory address.
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;

    // Memory depth for a pointer of the given width (wrap bit excluded).
    function automatic int fifo_depth(input int addr_width);
        return 1 << (addr_width - 1);
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterised combinational Gray-to-binary converter. Shared by the write-
// and read-side pointer blocks. Each binary bit is the XOR of all Gray bits
// at or above its position.
module fifo_gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Reduction-XOR of the Gray word shifted down to each bit position.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of an asynchronous FIFO.
// Optional feature: define FIFO_ALMOST_FULL_EN to add the registered
// walmost_full output (fill level at or above AF_THRESH).
//
// Handshake: a write is accepted on a rising wclk edge when winc=1 and the
// registered wfull=0. winc is a request, wfull acts as an inverted ready.
// A request made while full is dropped, the pointers hold and the sticky
// wovf flag is set.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AF_THRESH  = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH-1:0] wq2_rptr,
    output logic [ADDR_WIDTH-2:0] waddr,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH-1:0] wfill,
    output logic                  wovf
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                  walmost_full
`endif
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int MSB   = ADDR_WIDTH - 1;

    // Elaboration-time range check: an out-of-range threshold instantiates a
    // module that does not exist, so the build stops instead of misbehaving.
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
        fifo_af_thresh_out_of_range u_bad_af_thresh ();
    end

    logic [ADDR_WIDTH-1:0] wbin;
    logic [ADDR_WIDTH-1:0] wbin_next;
    logic [ADDR_WIDTH-1:0] wgnext;
    logic [ADDR_WIDTH-1:0] rbin;
    logic [ADDR_WIDTH-1:0] wfill_next;
    logic                  wfull_next;
    logic                  wovf_next;
    logic                  wr_accept;

    // Synchronised read pointer back to binary for the fill calculation.
    fifo_gray2bin #(
        .WIDTH (ADDR_WIDTH)
    ) u_rptr_gray2bin (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Next-state pointer, Gray, fill and flag computation.
    always_comb begin
        wr_accept  = winc & ~wfull;
        wbin_next  = wbin + {{(ADDR_WIDTH-1){1'b0}}, wr_accept};
        wgnext     = (wbin_next >> 1) ^ wbin_next;
        // Full when the write pointer is one lap ahead: top two Gray bits
        // inverted, remaining bits equal.
        wfull_next = (wgnext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]});
        wfill_next = wbin_next - rbin;
        wovf_next  = wovf | (winc & wfull);
    end

    // Pointer, flag and fill registers; reset dominates any write request.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            wfill <= '0;
            wovf  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgnext;
            wfull <= wfull_next;
            wfill <= wfill_next;
            wovf  <= wovf_next;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    // Almost-full flag registered from the same next fill level as wfill.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= (32'(wfill_next) >= AF_THRESH);
        end
    end
`endif

    assign waddr = wbin[ADDR_WIDTH-2:0];

endmodule
